// File: rtl/distance_fnd_display.sv
// Purpose: distance in cm -> four BCD digits (serial double-dabble) -> 4-digit multiplexed 7-seg drive.
// Latency: valid at edge N -> bcd_digits/bcd_ready at N+17; display follows on each digit's next scan tick.
// Backpressure: none; a valid during a conversion is parked in a one-deep latest-wins pending slot.
//
// Ports:
//   clk, reset (async, active-high)
//   distance[15:0], distance_valid : sampled together on the strobe cycle
//   bcd_digits[15:0], bcd_ready    : {thousands,hundreds,tens,ones}, one-cycle update pulse
//   seg[7:0] {dp,g..a} active-low, an[3:0] active-low digit enables (an[0] = ones)
// Optional feature: define DISTANCE_FND_ZERO_BLANK_EN to blank leading-zero digits.
module distance_fnd_display #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] distance,
  input  logic        distance_valid,
  output logic [15:0] bcd_digits,
  output logic        bcd_ready,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SCW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    bin_q, bin_d;
  logic [15:0]    bcd_q, bcd_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    pend_q, pend_d;
  logic           pend_v_q, pend_v_d;
  logic [15:0]    bcd_digits_q, bcd_digits_d;
  logic           bcd_ready_q, bcd_ready_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     an_q, an_d;
  logic [7:0]     seg_q, seg_d;

  logic [15:0] dist_clamped;
  logic [15:0] bcd_adj;
  logic [3:0]  digit_sel;
  logic [3:0]  blank;

  // Active-low {g..a} pattern for one decimal digit.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h7F;
    endcase
  endfunction

  assign dist_clamped = (distance > 16'd9999) ? 16'd9999 : distance;

  // Add-3 correction applied before every shift so each nibble stays decimal.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    bcd_digits_d = bcd_digits_q;
    bcd_ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (distance_valid) begin
          bin_d   = dist_clamped;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[14:0], bin_q[15]};
        bin_d = {bin_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
        if (distance_valid) begin
          pend_d   = dist_clamped;
          pend_v_d = 1'b1;
        end
      end
      DONE: begin
        bcd_digits_d = bcd_q;
        bcd_ready_d  = 1'b1;
        bcd_d        = '0;
        cnt_d        = '0;
        // A same-cycle valid is newer than anything parked, so it wins.
        if (distance_valid) begin
          bin_d    = dist_clamped;
          pend_v_d = 1'b0;
          state_d  = SHIFT;
        end else if (pend_v_q) begin
          bin_d    = pend_q;
          pend_v_d = 1'b0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Leading-zero mask: a digit blanks only when it and every higher digit are zero.
  always_comb begin
    blank = 4'b0000;
`ifdef DISTANCE_FND_ZERO_BLANK_EN
    blank[3] = (bcd_digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_digits_q[7:4] == 4'd0);
`endif
  end

  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    an_d       = an_q;
    seg_d      = seg_q;
    digit_sel  = '0;
    if (scan_cnt_q == SCAN_LAST) begin
      idx_d     = idx_q + 2'd1;
      digit_sel = bcd_digits_q[{idx_d, 2'b00} +: 4];
      an_d      = ~(4'b0001 << idx_d);
      seg_d     = blank[idx_d] ? 8'hFF : {1'b1, dec7(digit_sel)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      bcd_digits_q <= '0;
      bcd_ready_q  <= 1'b0;
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      bcd_digits_q <= bcd_digits_d;
      bcd_ready_q  <= bcd_ready_d;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bcd_digits = bcd_digits_q;
  assign bcd_ready  = bcd_ready_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_distance_fnd_display.sv
module tb_distance_fnd_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] distance;
  logic        distance_valid;
  logic [15:0] bcd_digits;
  logic        bcd_ready;
  logic [7:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;     // edges since reset release
  int shown_val = 0;  // decimal value the display should currently hold

  int          pw [4]      = '{1, 10, 100, 1000};
  logic [7:0]  seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  distance_fnd_display #(.CLK_HZ(1000), .SCAN_HZ(250)) dut (
    .clk(clk), .reset(reset), .distance(distance), .distance_valid(distance_valid),
    .bcd_digits(bcd_digits), .bcd_ready(bcd_ready), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  function automatic int clamp(input int d);
    return (d > 9999) ? 9999 : d;
  endfunction

  function automatic logic [15:0] model_bcd(input int d);
    int v;
    v = clamp(d);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] model_seg(input int idx, input int val);
`ifdef DISTANCE_FND_ZERO_BLANK_EN
    if (idx != 0 && val < pw[idx]) return 8'hFF;
`endif
    return seg_tbl[(val / pw[idx]) % 10];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; distance_valid = 1'b0; distance = '0;
    tick(); tick();
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_digits", 32'(bcd_digits), 32'h0);
    chk("rst_ready", 32'(bcd_ready), 32'h0);
    reset = 1'b0;
    shown_val = 0;
  endtask

  // Scan tick happens every 4th edge after release; tick k selects digit k mod 4.
  task automatic check_scan(input int n, input bit settle);
    int e, idx;
    if (settle) repeat (4) tick();
    for (int i = 0; i < n; i++) begin
      tick();
      e = ecnt;
      if (e < 4) begin
        chk("scan_an_pre", 32'(an), 32'hF);
        chk("scan_seg_pre", 32'(seg), 32'hFF);
      end else begin
        idx = (e / 4) % 4;
        chk("scan_an", 32'(an), 32'(4'hF & ~(4'h1 << idx)));
        chk("scan_seg", 32'(seg), 32'(model_seg(idx, shown_val)));
      end
    end
  endtask

  task automatic convert(input int d);
    int first, pulses;
    logic [15:0] got;
    first = 0; pulses = 0; got = '0;
    distance = 16'(d); distance_valid = 1'b1;
    tick();
    distance_valid = 1'b0; distance = 16'($urandom);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bcd_ready) begin
        pulses++;
        if (first == 0) begin first = k; got = bcd_digits; end
      end
    end
    chk("conv_latency", 32'(first), 32'd17);
    chk("conv_pulses", 32'(pulses), 32'd1);
    chk("conv_digits", 32'(got), 32'(model_bcd(d)));
    chk("conv_hold", 32'(bcd_digits), 32'(model_bcd(d)));
    shown_val = clamp(d);
  endtask

  // Valids at N, N+5, N+10: first completes at N+17, latest pending at N+34, middle dropped.
  task automatic b2b(input int a, input int b, input int c);
    int pulses;
    int pk [2];
    logic [15:0] pd [2];
    pulses = 0; pk = '{0, 0}; pd = '{16'h0, 16'h0};
    for (int k = 0; k <= 40; k++) begin
      distance_valid = (k == 0 || k == 5 || k == 10);
      distance = (k == 0) ? 16'(a) : (k == 5) ? 16'(b) : 16'(c);
      tick();
      distance_valid = 1'b0;
      if (bcd_ready) begin
        if (pulses < 2) begin pk[pulses] = k; pd[pulses] = bcd_digits; end
        pulses++;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_t0", 32'(pk[0]), 32'd17);
    chk("b2b_d0", 32'(pd[0]), 32'(model_bcd(a)));
    chk("b2b_t1", 32'(pk[1]), 32'd34);
    chk("b2b_d1", 32'(pd[1]), 32'(model_bcd(c)));
    shown_val = clamp(c);
  endtask

  initial begin
    int pulses, d;
    reset = 1'b1; distance_valid = 1'b0; distance = '0;

    do_reset();
    check_scan(8, 1'b0);

    convert(123);
    check_scan(16, 1'b1);

    convert(16'hFFFF);
    convert(400);
    convert(9999);
    convert(10000);

    b2b(45, 400, 7);

    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 1) ? int'($urandom_range(0, 9999)) : int'($urandom & 32'hFFFF);
      convert(d);
    end
    check_scan(8, 1'b1);

    for (int i = 0; i < 2; i++) begin
      b2b(int'($urandom & 32'hFFFF), int'($urandom_range(0, 9999)), int'($urandom_range(0, 9999)));
      check_scan(4, 1'b1);
    end

    convert(0);
    check_scan(16, 1'b1);

    // Reset at N+8 with a value also parked in the pending slot.
    distance = 16'd500; distance_valid = 1'b1;
    tick();
    distance_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      distance_valid = (k == 3);
      distance = 16'd777;
      tick();
    end
    distance_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_digits", 32'(bcd_digits), 32'h0);
    chk("mid_rst_ready", 32'(bcd_ready), 32'h0);
    tick();
    reset = 1'b0;
    shown_val = 0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bcd_ready) pulses++;
    end
    chk("mid_rst_no_ready", 32'(pulses), 32'd0);
    chk("mid_rst_digits_after", 32'(bcd_digits), 32'h0);

    convert(250);
    check_scan(8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
